// File: rtl/eth_10g_rx_st_pkt_arbiter.sv
// Packet-aware 2:1 round-robin arbiter for the 10G MAC RX Avalon-ST frame path.
// Grants whole packets and drives a registered output beat that honours sink backpressure.
module eth_10g_rx_st_pkt_arbiter #(
  parameter int DATA_W  = 64,
  parameter int EMPTY_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,

  input  logic               in0_valid,
  output logic               in0_ready,
  input  logic [DATA_W-1:0]  in0_data,
  input  logic               in0_error,
  input  logic               in0_startofpacket,
  input  logic               in0_endofpacket,
  input  logic [EMPTY_W-1:0] in0_empty,

  input  logic               in1_valid,
  output logic               in1_ready,
  input  logic [DATA_W-1:0]  in1_data,
  input  logic               in1_error,
  input  logic               in1_startofpacket,
  input  logic               in1_endofpacket,
  input  logic [EMPTY_W-1:0] in1_empty,

  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_error,
  output logic               out_startofpacket,
  output logic               out_endofpacket,
  output logic [EMPTY_W-1:0] out_empty,
  output logic               out_channel,

  output logic [CNT_W-1:0]   pkt_cnt0,
  output logic [CNT_W-1:0]   pkt_cnt1,
  output logic [CNT_W-1:0]   orphan_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               error;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } beat_t;

  state_t           state, state_nxt;
  logic             last_grant, last_grant_nxt;
  logic             space;
  logic             cand0, cand1;
  logic             grant0, grant1;
  logic             fwd, fwd_sel;
  logic             orphan0, orphan1;
  logic             pkt_inc0, pkt_inc1;
  beat_t            beat0, beat1, fwd_beat;
  logic [CNT_W:0]   orphan_sum;
  logic [CNT_W-1:0] orphan_nxt;

  assign beat0 = {in0_data, in0_error, in0_startofpacket, in0_endofpacket, in0_empty};
  assign beat1 = {in1_data, in1_error, in1_startofpacket, in1_endofpacket, in1_empty};

  assign space = !out_valid || out_ready;

  // Round-robin tie break: on a tie the source that did not win last time is granted.
  assign cand0  = in0_valid && in0_startofpacket;
  assign cand1  = in1_valid && in1_startofpacket;
  assign grant0 = cand0 && (!cand1 || last_grant);
  assign grant1 = cand1 && (!cand0 || !last_grant);

  assign fwd_sel  = (state == LOCK1) || ((state == IDLE) && grant1);
  assign fwd_beat = fwd_sel ? beat1 : beat0;

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that leaves one
    // unassigned would make it hold its old value, i.e. infer a latch.
    state_nxt      = state;
    last_grant_nxt = last_grant;
    in0_ready      = 1'b0;
    in1_ready      = 1'b0;
    fwd            = 1'b0;
    orphan0        = 1'b0;
    orphan1        = 1'b0;
    pkt_inc0       = 1'b0;
    pkt_inc1       = 1'b0;

    case (state)
      IDLE: begin
        // Non-SOP beats outside a packet are swallowed so they cannot block arbitration.
        orphan0   = in0_valid && !in0_startofpacket;
        orphan1   = in1_valid && !in1_startofpacket;
        in0_ready = orphan0 || (grant0 && space);
        in1_ready = orphan1 || (grant1 && space);
        if ((grant0 || grant1) && space) begin
          fwd            = 1'b1;
          last_grant_nxt = grant1;
          if (fwd_beat.eop) begin
            pkt_inc0 = grant0;
            pkt_inc1 = grant1;
          end else begin
            state_nxt = grant1 ? LOCK1 : LOCK0;
          end
        end
      end

      LOCK0: begin
        in0_ready = space;
        fwd       = in0_valid && space;
        if (fwd && in0_endofpacket) begin
          pkt_inc0  = 1'b1;
          state_nxt = IDLE;
        end
      end

      LOCK1: begin
        in1_ready = space;
        fwd       = in1_valid && space;
        if (fwd && in1_endofpacket) begin
          pkt_inc1  = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Two orphans can arrive in one cycle, so the carry out of the sum detects saturation.
  assign orphan_sum = {1'b0, orphan_cnt} + (CNT_W+1)'(orphan0) + (CNT_W+1)'(orphan1);
  assign orphan_nxt = orphan_sum[CNT_W] ? '1 : orphan_sum[CNT_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values no matter in which order the simulator evaluates processes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      last_grant        <= 1'b1;
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_error         <= 1'b0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_empty         <= '0;
      out_channel       <= 1'b0;
      pkt_cnt0          <= '0;
      pkt_cnt1          <= '0;
      orphan_cnt        <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;

      if (fwd) begin
        out_valid         <= 1'b1;
        out_data          <= fwd_beat.data;
        out_error         <= fwd_beat.error;
        out_startofpacket <= fwd_beat.sop;
        out_endofpacket   <= fwd_beat.eop;
        out_empty         <= fwd_beat.empty;
        out_channel       <= fwd_sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (pkt_inc0) pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
      if (pkt_inc1) pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
      orphan_cnt <= orphan_nxt;
    end
  end

endmodule

// File: tb/tb_eth_10g_rx_st_pkt_arbiter.sv
// Self-checking bench for eth_10g_rx_st_pkt_arbiter: vector table, directed corner
// sequences and a randomized run scored against a packet-level reference model.
module tb_eth_10g_rx_st_pkt_arbiter;
  localparam int DATA_W  = 64;
  localparam int EMPTY_W = 3;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               in0_valid, in0_ready, in0_error, in0_startofpacket, in0_endofpacket;
  logic [DATA_W-1:0]  in0_data;
  logic [EMPTY_W-1:0] in0_empty;
  logic               in1_valid, in1_ready, in1_error, in1_startofpacket, in1_endofpacket;
  logic [DATA_W-1:0]  in1_data;
  logic [EMPTY_W-1:0] in1_empty;
  logic               out_valid, out_ready, out_error, out_startofpacket, out_endofpacket;
  logic               out_channel;
  logic [DATA_W-1:0]  out_data;
  logic [EMPTY_W-1:0] out_empty;
  logic [CNT_W-1:0]   pkt_cnt0, pkt_cnt1, orphan_cnt;

  always #5 clk = ~clk;

  eth_10g_rx_st_pkt_arbiter #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data), .in0_error(in0_error),
    .in0_startofpacket(in0_startofpacket), .in0_endofpacket(in0_endofpacket), .in0_empty(in0_empty),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data), .in1_error(in1_error),
    .in1_startofpacket(in1_startofpacket), .in1_endofpacket(in1_endofpacket), .in1_empty(in1_empty),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_error(out_error),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket), .out_empty(out_empty),
    .out_channel(out_channel),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .orphan_cnt(orphan_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input bit v, input bit s, input bit e, input logic [63:0] d, input logic [2:0] m);
    in0_valid = v; in0_startofpacket = s; in0_endofpacket = e; in0_data = d; in0_empty = m; in0_error = 1'b0;
  endtask

  task automatic drive1(input bit v, input bit s, input bit e, input logic [63:0] d, input logic [2:0] m);
    in1_valid = v; in1_startofpacket = s; in1_endofpacket = e; in1_data = d; in1_empty = m; in1_error = 1'b0;
  endtask

  task automatic do_reset();
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    out_ready = 1'b1;
    reset     = 1'b1;
    tick();
    reset     = 1'b0;
  endtask

  // One cycle of stimulus with the expected readies (this cycle) and out beat (after the edge).
  typedef struct {
    bit rst;
    bit v0, s0, e0; logic [63:0] d0; logic [2:0] m0;
    bit v1, s1, e1; logic [63:0] d1; logic [2:0] m1;
    bit x_r0, x_r1, x_ov;
    logic [63:0] x_od; bit x_ch, x_sop, x_eop; logic [2:0] x_emp;
  } vec_t;

  function automatic vec_t mk(bit rst,
                              bit v0, bit s0, bit e0, logic [63:0] d0, logic [2:0] m0,
                              bit v1, bit s1, bit e1, logic [63:0] d1, logic [2:0] m1,
                              bit r0, bit r1, bit ov, logic [63:0] od, bit ch, bit sop, bit eop,
                              logic [2:0] emp);
    vec_t t;
    t.rst = rst;
    t.v0 = v0; t.s0 = s0; t.e0 = e0; t.d0 = d0; t.m0 = m0;
    t.v1 = v1; t.s1 = s1; t.e1 = e1; t.d1 = d1; t.m1 = m1;
    t.x_r0 = r0; t.x_r1 = r1; t.x_ov = ov; t.x_od = od;
    t.x_ch = ch; t.x_sop = sop; t.x_eop = eop; t.x_emp = emp;
    return t;
  endfunction

  typedef struct { logic [63:0] d; logic [6:0] meta; } exp_t;

  task automatic run_random(input int ncyc);
    bit          g_v[2], g_s[2], g_e[2], g_err[2];
    logic [63:0] g_d[2];
    logic [2:0]  g_m[2];
    int          g_rem[2];
    int          m_lock, m_last, m_orphan, win, fwd_src;
    int          m_pkt[2];
    bit          m_ov, space, gen;
    bit          r[2];
    exp_t        q[$];
    exp_t        e;
    m_lock = -1; m_last = 1; m_orphan = 0; m_ov = 0;
    for (int n = 0; n < 2; n++) begin
      g_v[n] = 0; g_s[n] = 0; g_e[n] = 0; g_err[n] = 0; g_d[n] = 0; g_m[n] = 0; g_rem[n] = 0; m_pkt[n] = 0;
    end
    for (int c = 0; c < ncyc; c++) begin
      gen = (c < ncyc - 24);
      // Sources emit mostly well-formed packets, with occasional orphans and stray SOPs.
      for (int n = 0; n < 2; n++) begin
        if (gen && !g_v[n] && $urandom_range(99) < 70) begin
          g_v[n]   = 1;
          g_err[n] = ($urandom_range(15) == 0);
          g_d[n]   = {$urandom, $urandom};
          g_m[n]   = 3'($urandom_range(7));
          if (g_rem[n] == 0) begin
            if ($urandom_range(9) == 0) begin
              g_s[n] = 0; g_e[n] = 1'($urandom_range(1));
            end else begin
              g_rem[n] = $urandom_range(4, 1);
              g_s[n] = 1; g_e[n] = (g_rem[n] == 1); g_rem[n]--;
            end
          end else begin
            g_s[n] = ($urandom_range(19) == 0); g_e[n] = (g_rem[n] == 1); g_rem[n]--;
          end
        end
      end
      in0_valid = g_v[0]; in0_startofpacket = g_s[0]; in0_endofpacket = g_e[0];
      in0_data = g_d[0]; in0_empty = g_m[0]; in0_error = g_err[0];
      in1_valid = g_v[1]; in1_startofpacket = g_s[1]; in1_endofpacket = g_e[1];
      in1_data = g_d[1]; in1_empty = g_m[1]; in1_error = g_err[1];
      out_ready = gen ? ($urandom_range(3) != 0) : 1'b1;
      #1;

      space = !m_ov || out_ready;
      r[0] = 0; r[1] = 0; win = -1;
      if (m_lock < 0) begin
        if (g_v[0] && g_s[0] && g_v[1] && g_s[1]) win = 1 - m_last;
        else if (g_v[0] && g_s[0]) win = 0;
        else if (g_v[1] && g_s[1]) win = 1;
        for (int n = 0; n < 2; n++) if (g_v[n] && !g_s[n]) r[n] = 1;
        if (win >= 0 && space) r[win] = 1;
      end else if (space) begin
        r[m_lock] = 1;
      end
      check("rnd_rdy0", in0_ready, r[0]);
      check("rnd_rdy1", in1_ready, r[1]);
      check("rnd_out_valid", out_valid, m_ov);
      if (m_ov && out_ready) begin
        if (q.size() == 0) begin
          check("rnd_sb_underflow", 1, 0);
        end else begin
          e = q.pop_front();
          check("rnd_out_data", out_data, e.d);
          check("rnd_out_meta",
                {out_error, out_startofpacket, out_endofpacket, out_empty, out_channel}, e.meta);
        end
      end

      fwd_src = -1;
      if (m_lock < 0) begin
        for (int n = 0; n < 2; n++) begin
          if (g_v[n] && !g_s[n]) begin
            m_orphan = (m_orphan < 65535) ? m_orphan + 1 : 65535;
            g_v[n] = 0;
          end
        end
        if (win >= 0 && space) begin
          fwd_src = win; m_last = win;
          if (g_e[win]) m_pkt[win]++;
          else m_lock = win;
        end
      end else if (space && g_v[m_lock]) begin
        fwd_src = m_lock;
        if (g_e[m_lock]) begin m_pkt[m_lock]++; m_lock = -1; end
      end
      if (fwd_src >= 0) begin
        e.d    = g_d[fwd_src];
        e.meta = {g_err[fwd_src], g_s[fwd_src], g_e[fwd_src], g_m[fwd_src], 1'(fwd_src)};
        q.push_back(e);
        g_v[fwd_src] = 0;
        m_ov = 1;
      end else if (out_ready) begin
        m_ov = 0;
      end
      tick();
      check("rnd_pkt_cnt0", pkt_cnt0, m_pkt[0] & 16'hFFFF);
      check("rnd_pkt_cnt1", pkt_cnt1, m_pkt[1] & 16'hFFFF);
      check("rnd_orphan_cnt", orphan_cnt, m_orphan);
    end
    check("rnd_drained", q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[10];
    logic [63:0] pd[4];

    vecs[0] = mk(0, 1,1,0,64'hA0,0,    0,0,0,0,0,        1,0, 1,64'hA0,0,1,0,0);
    vecs[1] = mk(0, 1,0,0,64'h1111,0,  0,0,0,0,0,        1,0, 1,64'h1111,0,0,0,0);
    vecs[2] = mk(0, 1,0,1,64'hA2,5,    0,0,0,0,0,        1,0, 1,64'hA2,0,0,1,5);
    vecs[3] = mk(0, 0,0,0,0,0,         0,0,0,0,0,        0,0, 0,0,0,0,0,0);
    vecs[4] = mk(1, 1,1,0,64'hB0,0,    1,1,0,64'hC0,0,   1,0, 1,64'hB0,0,1,0,0);
    vecs[5] = mk(0, 1,0,1,64'hB1,2,    1,1,0,64'hC0,0,   1,0, 1,64'hB1,0,0,1,2);
    vecs[6] = mk(0, 1,1,0,64'hD0,0,    1,1,0,64'hC0,0,   0,1, 1,64'hC0,1,1,0,0);
    vecs[7] = mk(0, 1,1,0,64'hD0,0,    1,0,1,64'hC1,7,   0,1, 1,64'hC1,1,0,1,7);
    vecs[8] = mk(0, 1,1,1,64'hD0,1,    0,0,0,0,0,        1,0, 1,64'hD0,0,1,1,1);
    vecs[9] = mk(0, 0,0,0,0,0,         0,0,0,0,0,        0,0, 0,0,0,0,0,0);

    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_flags", {out_error, out_startofpacket, out_endofpacket, out_channel}, 0);
    check("rst_out_empty", out_empty, 0);
    check("rst_counters", {pkt_cnt0, pkt_cnt1, orphan_cnt}, 0);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].rst) do_reset();
      drive0(vecs[i].v0, vecs[i].s0, vecs[i].e0, vecs[i].d0, vecs[i].m0);
      drive1(vecs[i].v1, vecs[i].s1, vecs[i].e1, vecs[i].d1, vecs[i].m1);
      out_ready = 1'b1;
      #1;
      check($sformatf("tbl%0d_rdy0", i), in0_ready, vecs[i].x_r0);
      check($sformatf("tbl%0d_rdy1", i), in1_ready, vecs[i].x_r1);
      tick();
      check($sformatf("tbl%0d_out_valid", i), out_valid, vecs[i].x_ov);
      if (vecs[i].x_ov) begin
        check($sformatf("tbl%0d_out_data", i), out_data, vecs[i].x_od);
        check($sformatf("tbl%0d_out_chan", i), out_channel, vecs[i].x_ch);
        check($sformatf("tbl%0d_out_sop_eop", i), {out_startofpacket, out_endofpacket},
              {vecs[i].x_sop, vecs[i].x_eop});
        check($sformatf("tbl%0d_out_empty", i), out_empty, vecs[i].x_emp);
      end
      if (i == 3) check("tbl_pkt_cnt0_a", pkt_cnt0, 1);
      if (i == 9) check("tbl_pkt_cnts_b", {pkt_cnt0, pkt_cnt1}, {16'd2, 16'd1});
    end

    // Backpressure: out_ready low for 4 cycles while in0 is mid-packet.
    do_reset();
    pd[0] = 64'h5000; pd[1] = 64'h5001; pd[2] = 64'h5002; pd[3] = 64'h5003;
    drive0(1, 1, 0, pd[0], 0);
    #1; check("bp_rdy_sop", in0_ready, 1);
    tick(); check("bp_out_sop", out_data, pd[0]);
    out_ready = 1'b0;
    drive0(1, 0, 0, pd[1], 0);
    for (int k = 0; k < 4; k++) begin
      #1; check("bp_rdy_stall", in0_ready, 0);
      tick();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data", out_data, pd[0]);
    end
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      drive0(1, 0, k == 3, pd[k], (k == 3) ? 3'd4 : 3'd0);
      #1; check("bp_rdy_resume", in0_ready, 1);
      tick();
      check("bp_out_data", out_data, pd[k]);
      check("bp_out_eop", out_endofpacket, k == 3);
    end
    drive0(0, 0, 0, 0, 0);
    tick();
    check("bp_out_idle", out_valid, 0);
    check("bp_pkt_cnt0", pkt_cnt0, 1);

    // Orphans in IDLE, then drive the counter into saturation with paired orphans.
    do_reset();
    drive1(1, 0, 0, 64'hBAD, 0);
    for (int k = 0; k < 3; k++) begin
      #1; check("orph_rdy1", in1_ready, 1);
      tick(); check("orph_no_out", out_valid, 0);
    end
    drive1(0, 0, 0, 0, 0);
    check("orph_cnt3", orphan_cnt, 3);
    drive0(1, 0, 0, 64'hBAD0, 0);
    drive1(1, 0, 0, 64'hBAD1, 0);
    repeat (32765) tick();
    check("orph_cnt_65533", orphan_cnt, 65533);
    drive1(0, 0, 0, 0, 0);
    tick(); check("orph_cnt_65534", orphan_cnt, 65534);
    drive1(1, 0, 0, 64'hBAD1, 0);
    tick(); check("orph_sat_pair", orphan_cnt, 16'hFFFF);
    tick(); check("orph_sat_hold", orphan_cnt, 16'hFFFF);

    // Single-beat packet on in1, then competing SOPs: in0 must win the tie.
    do_reset();
    drive0(0, 0, 0, 0, 0);
    drive1(1, 1, 1, 64'h5151, 6);
    #1; check("sb_rdy1", in1_ready, 1);
    tick();
    check("sb_out", {out_data, out_channel, out_startofpacket, out_endofpacket, out_empty},
          {64'h5151, 1'b1, 1'b1, 1'b1, 3'd6});
    check("sb_pkt_cnt1", pkt_cnt1, 1);
    drive0(1, 1, 0, 64'h7000, 0);
    drive1(1, 1, 0, 64'h8000, 0);
    #1;
    check("sb_next_rdy0", in0_ready, 1);
    check("sb_next_rdy1", in1_ready, 0);
    tick();
    check("sb_next_out", {out_data, out_channel}, {64'h7000, 1'b0});
    drive1(0, 0, 0, 0, 0);
    drive0(1, 0, 1, 64'h7001, 0);
    tick();
    check("sb_in0_eop", {out_data, out_endofpacket}, {64'h7001, 1'b1});
    check("sb_pkt_cnt0", pkt_cnt0, 1);

    // Reset while LOCK0 is mid-packet: beat dropped, counters cleared, in1 accepted at once.
    drive0(1, 1, 0, 64'h9000, 0);
    tick();
    check("rl_lock_out", out_data, 64'h9000);
    drive0(1, 0, 0, 64'h9001, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rl_out_valid", out_valid, 0);
    check("rl_out_data", out_data, 0);
    check("rl_counters", {pkt_cnt0, pkt_cnt1, orphan_cnt}, 0);
    drive0(0, 0, 0, 0, 0);
    drive1(1, 1, 0, 64'hA000, 0);
    #1; check("rl_in1_rdy", in1_ready, 1);
    tick();
    check("rl_in1_out", {out_valid, out_data, out_channel}, {1'b1, 64'hA000, 1'b1});
    drive1(1, 0, 1, 64'hA001, 3);
    tick();
    drive1(0, 0, 0, 0, 0);
    check("rl_pkt_cnt1", pkt_cnt1, 1);
    tick();

    do_reset();
    run_random(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
